// File: rtl/clk_edge_align_monitor.sv
// clk_edge_align_monitor
// Watches the three outputs of the aligned-clock generator (A fast, B mid,
// C slow), measures each channel's rising-edge period in sampling-clock
// cycles, checks that every B and C rise lands on an A rise, and walks a
// small FSM from arming through lock, dropping to FAULT on any new error.
module clk_edge_align_monitor #(
  parameter int CNT_W  = 8,
  parameter int EXP_A  = 4,
  parameter int EXP_B  = 8,
  parameter int EXP_C  = 16,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sig_a,
  input  logic             sig_b,
  input  logic             sig_c,
  output logic             locked,
  output logic             fault,
  output logic [2:0]       err_period,
  output logic [1:0]       err_align,
  output logic [CNT_W-1:0] meas_a,
  output logic [CNT_W-1:0] meas_b,
  output logic [CNT_W-1:0] meas_c
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMING,
    S_CHECK,
    S_LOCKED,
    S_FAULT
  } state_t;

  state_t             state, state_nx;
  logic [GOOD_W-1:0]  good_cnt, good_nx;
  logic               locked_nx, fault_nx;

  logic [2:0]         sig, sig_d, rise, arm, perr;
  logic [1:0]         aerr;
  logic               new_err;
  logic [CNT_W-1:0]   meas [3];

  // Bit index 0/1/2 is channel A/B/C throughout.
  assign sig  = {sig_c, sig_b, sig_a};
  assign rise = en ? (sig & ~sig_d) : 3'b000;

  // Previous-sample registers used for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_d <= '0;
    else     sig_d <= sig;
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    localparam int EXP_I = (i == 0) ? EXP_A : ((i == 1) ? EXP_B : EXP_C);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] meas_q;
    logic             arm_q;
    logic             sat;
    logic [CNT_W:0]   period;

    // A saturated counter means the true period is unknown and too long,
    // so it is reported as the maximum and always counts as a mismatch.
    assign sat     = &cnt_q;
    assign period  = {1'b0, cnt_q} + 1'b1;
    assign perr[i] = rise[i] & arm_q & (sat | (period != (CNT_W+1)'(EXP_I)));
    assign arm[i]  = arm_q;
    assign meas[i] = meas_q;

    // Saturating period counter, last measured period and arm flag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        meas_q <= '0;
        arm_q  <= 1'b0;
      end else if (!en) begin
        cnt_q  <= '0;
        arm_q  <= 1'b0;
      end else begin
        if (rise[i]) begin
          cnt_q  <= '0;
          meas_q <= sat ? cnt_q : period[CNT_W-1:0];
        end else if (!sat) begin
          cnt_q  <= cnt_q + 1'b1;
        end
        if (clr)          arm_q <= 1'b0;
        else if (rise[i]) arm_q <= 1'b1;
      end
    end
  end

  assign meas_a = meas[0];
  assign meas_b = meas[1];
  assign meas_c = meas[2];

  // Alignment is only meaningful once the channels involved have a
  // reference edge, hence the arm qualifiers.
  assign aerr[0] = rise[1] & ~rise[0] & arm[0] & arm[1];
  assign aerr[1] = rise[2] & ~(rise[0] & rise[1]) & (&arm);
  assign new_err = (|perr) | (|aerr);

  // Sticky error flags; a clear in the same cycle as a new error wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_period <= '0;
      err_align  <= '0;
    end else if (clr) begin
      err_period <= '0;
      err_align  <= '0;
    end else begin
      err_period <= err_period | perr;
      err_align  <= err_align | aerr;
    end
  end

  // State register with registered lock/fault decodes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      good_cnt <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
      locked   <= locked_nx;
      fault    <= fault_nx;
    end
  end

  // Next-state logic: disable dominates, then clear, then per-state rules
  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    if (!en) begin
      state_nx = S_IDLE;
      good_nx  = '0;
    end else if (clr) begin
      state_nx = S_ARMING;
      good_nx  = '0;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_ARMING;
        S_ARMING: begin
          if (new_err) begin
            state_nx = S_FAULT;
          end else if (&arm) begin
            state_nx = S_CHECK;
            good_nx  = '0;
          end
        end
        S_CHECK: begin
          if (new_err) begin
            state_nx = S_FAULT;
          end else if (rise[2]) begin
            good_nx = good_cnt + 1'b1;
            if (good_cnt == GOOD_W'(LOCK_N - 1)) state_nx = S_LOCKED;
          end
        end
        S_LOCKED: if (new_err) state_nx = S_FAULT;
        S_FAULT:  state_nx = S_FAULT;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Status decodes of the upcoming state so they track state exactly
  always_comb begin
    locked_nx = (state_nx == S_LOCKED);
    fault_nx  = (state_nx == S_FAULT);
  end

endmodule

// File: tb/tb_clk_edge_align_monitor.sv
// Testbench for clk_edge_align_monitor: generates the 1:2:4 clock family
// from a phase counter with optional distortions, and predicts outputs
// from a period/alignment model built on absolute edge timestamps.
module tb_clk_edge_align_monitor;

  localparam int CNT_W  = 8;
  localparam int EXP_A  = 4;
  localparam int EXP_B  = 8;
  localparam int EXP_C  = 16;
  localparam int LOCK_N = 3;
  localparam int SAT    = 255;

  logic             clk = 1'b0;
  logic             rst, en, clr, sig_a, sig_b, sig_c;
  logic             locked, fault;
  logic [2:0]       err_period;
  logic [1:0]       err_align;
  logic [CNT_W-1:0] meas_a, meas_b, meas_c;

  int n_checks = 0;
  int n_fail   = 0;

  // Waveform generator controls
  int ph     = 0;
  int b_off  = 0;
  int c_off  = 0;
  bit a_low  = 1'b0;
  int glitch = 0;

  // Reference model state
  int       edge_n = 0;
  bit [2:0] m_prev;
  int       m_last [3];
  bit [2:0] m_armed;
  int       m_meas [3];
  bit [2:0] m_ep;
  bit [1:0] m_ea;
  bit       m_active, m_check, m_lock, m_fault;
  int       m_good;
  int       exp_per [3] = '{EXP_A, EXP_B, EXP_C};

  clk_edge_align_monitor #(
    .CNT_W (CNT_W),
    .EXP_A (EXP_A),
    .EXP_B (EXP_B),
    .EXP_C (EXP_C),
    .LOCK_N(LOCK_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .sig_a     (sig_a),
    .sig_b     (sig_b),
    .sig_c     (sig_c),
    .locked    (locked),
    .fault     (fault),
    .err_period(err_period),
    .err_align (err_align),
    .meas_a    (meas_a),
    .meas_b    (meas_b),
    .meas_c    (meas_c)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] dut_vec();
    return {locked, fault, err_period, err_align, meas_a, meas_b, meas_c};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {m_lock, m_fault, m_ep, m_ea,
            8'(m_meas[0]), 8'(m_meas[1]), 8'(m_meas[2])};
  endfunction

  task automatic model_reset();
    m_prev   = '0;
    m_armed  = '0;
    m_ep     = '0;
    m_ea     = '0;
    m_active = 1'b0;
    m_check  = 1'b0;
    m_lock   = 1'b0;
    m_fault  = 1'b0;
    m_good   = 0;
    for (int i = 0; i < 3; i++) begin
      m_last[i] = edge_n;
      m_meas[i] = 0;
    end
  endtask

  // Periods are differences of edge timestamps; a disabled or reset
  // monitor restarts the timestamp reference at the current edge.
  task automatic model_edge(input bit [2:0] s);
    bit [2:0] r;
    bit [2:0] pe;
    bit [1:0] ae;
    bit       nerr;
    int       per;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    r      = en ? (s & ~m_prev) : 3'b000;
    m_prev = s;
    if (!en) begin
      for (int i = 0; i < 3; i++) m_last[i] = edge_n;
      m_armed  = '0;
      m_active = 1'b0;
      m_check  = 1'b0;
      m_lock   = 1'b0;
      m_fault  = 1'b0;
      m_good   = 0;
      if (clr) begin
        m_ep = '0;
        m_ea = '0;
      end
      return;
    end
    pe = '0;
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        per       = edge_n - m_last[i];
        m_meas[i] = (per > SAT) ? SAT : per;
        if (m_armed[i] && per != exp_per[i]) pe[i] = 1'b1;
        m_last[i] = edge_n;
      end
    end
    ae[0] = r[1] && !r[0] && m_armed[0] && m_armed[1];
    ae[1] = r[2] && !(r[0] && r[1]) && (&m_armed);
    nerr  = (pe != 0) || (ae != 0);
    if (clr) begin
      m_active = 1'b1;
      m_check  = 1'b0;
      m_lock   = 1'b0;
      m_fault  = 1'b0;
      m_good   = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
    end else if (m_fault) begin
      m_fault = 1'b1;
    end else if (nerr) begin
      m_fault = 1'b1;
      m_lock  = 1'b0;
      m_check = 1'b0;
    end else if (!m_check && !m_lock) begin
      if (&m_armed) begin
        m_check = 1'b1;
        m_good  = 0;
      end
    end else if (m_check && r[2]) begin
      m_good++;
      if (m_good == LOCK_N) begin
        m_check = 1'b0;
        m_lock  = 1'b1;
      end
    end
    if (clr) begin
      m_ep    = '0;
      m_ea    = '0;
      m_armed = '0;
    end else begin
      m_ep    = m_ep | pe;
      m_ea    = m_ea | ae;
      m_armed = m_armed | r;
    end
  endtask

  // One sampling cycle: drive the waveforms for phase ph, let the edge
  // happen, advance the model, and settle just after the edge.
  task automatic tick();
    bit [2:0] s;
    s[0] = a_low ? 1'b0 : (((ph + 64) % 4) < 2);
    s[1] = (((ph + 64 - b_off) % 8) < 4);
    s[2] = (((ph + 64 - c_off) % 16) < 8);
    if (glitch != 0)
      for (int i = 0; i < 3; i++)
        if ($urandom_range(glitch - 1) == 0) s[i] = ~s[i];
    sig_a = s[0];
    sig_b = s[1];
    sig_c = s[2];
    @(posedge clk);
    model_edge(s);
    #1;
    ph++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    sig_a = 1'b0; sig_b = 1'b0; sig_c = 1'b0;
    model_reset();
    repeat (2) tick();
    n_checks++;
    if (dut_vec() !== 31'd0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got %h expected 0", dut_vec());
    end
    #2 rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL idle_outputs: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_ideal_lock();
    while (ph % 16 != 0) tick();
    en = 1'b1;
    repeat (48) tick();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ideal_lock_early: got %b expected 0", locked);
    end
    tick();
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ideal_locked: got %b expected 1", locked);
    end
    n_checks++;
    if ({meas_a, meas_b, meas_c} !== {8'd4, 8'd8, 8'd16}) begin
      n_fail++; $display("[TB] FAIL ideal_meas: got %0d/%0d/%0d expected 4/8/16", meas_a, meas_b, meas_c);
    end
    n_checks++;
    if ({fault, err_period, err_align} !== 6'd0) begin
      n_fail++; $display("[TB] FAIL ideal_errors: got fault=%b ep=%b ea=%b expected all 0", fault, err_period, err_align);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL ideal_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_b_stretch();
    while (ph % 8 != 4) tick();
    b_off = 1;
    repeat (5) tick();
    n_checks++;
    if ({locked, fault, err_period, err_align} !== 7'b1000000) begin
      n_fail++; $display("[TB] FAIL bstretch_before: got l=%b f=%b ep=%b ea=%b expected locked only", locked, fault, err_period, err_align);
    end
    tick();
    n_checks++;
    if (err_period !== 3'b010) begin
      n_fail++; $display("[TB] FAIL bstretch_err_period: got %b expected 010", err_period);
    end
    n_checks++;
    if (err_align !== 2'b01) begin
      n_fail++; $display("[TB] FAIL bstretch_err_align: got %b expected 01", err_align);
    end
    n_checks++;
    if ({fault, locked} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL bstretch_state: got fault=%b locked=%b expected 1/0", fault, locked);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL bstretch_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_clr_relock();
    b_off = 0;
    while (ph % 16 != 1) tick();
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++; $display("[TB] FAIL clr_fault_held: got %b expected 1", fault);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if ({locked, fault, err_period, err_align} !== 7'd0) begin
      n_fail++; $display("[TB] FAIL clr_cleared: got l=%b f=%b ep=%b ea=%b expected all 0", locked, fault, err_period, err_align);
    end
    repeat (62) tick();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr_lock_early: got %b expected 0", locked);
    end
    tick();
    n_checks++;
    if ({locked, fault, err_period, err_align} !== 7'b1000000) begin
      n_fail++; $display("[TB] FAIL clr_relocked: got l=%b f=%b ep=%b ea=%b expected locked only", locked, fault, err_period, err_align);
    end
  endtask

  task automatic test_c_shift();
    en = 1'b0;
    tick();
    n_checks++;
    if ({locked, fault} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL disable_idle: got locked=%b fault=%b expected 0/0", locked, fault);
    end
    c_off = 1;
    while (ph % 16 != 0) tick();
    en = 1'b1;
    repeat (17) tick();
    n_checks++;
    if ({fault, err_period, err_align} !== 6'd0) begin
      n_fail++; $display("[TB] FAIL cshift_arming: got f=%b ep=%b ea=%b expected all 0", fault, err_period, err_align);
    end
    tick();
    n_checks++;
    if ({fault, err_period, err_align} !== 6'b1_000_10) begin
      n_fail++; $display("[TB] FAIL cshift_align: got f=%b ep=%b ea=%b expected 1/000/10", fault, err_period, err_align);
    end
    n_checks++;
    if (meas_c !== 8'd16) begin
      n_fail++; $display("[TB] FAIL cshift_meas_c: got %0d expected 16", meas_c);
    end
  endtask

  task automatic test_stuck_a();
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    c_off = 0;
    while (ph % 16 != 0) tick();
    en = 1'b1;
    tick();
    a_low = 1'b1;
    repeat (300) tick();
    while (ph % 4 != 0) tick();
    n_checks++;
    if ({locked, err_period} !== 4'd0) begin
      n_fail++; $display("[TB] FAIL stuck_before: got locked=%b ep=%b expected 0/000", locked, err_period);
    end
    a_low = 1'b0;
    tick();
    n_checks++;
    if (meas_a !== 8'd255) begin
      n_fail++; $display("[TB] FAIL stuck_meas_a: got %0d expected 255", meas_a);
    end
    n_checks++;
    if ({locked, fault, err_period, err_align} !== 7'b0_1_001_11) begin
      n_fail++; $display("[TB] FAIL stuck_flags: got l=%b f=%b ep=%b ea=%b expected 0/1/001/11", locked, fault, err_period, err_align);
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL stuck_model: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    while (ph % 16 != 0) tick();
    en = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (dut_vec() !== exp_vec() || locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midcheck_model: got %h expected %h", dut_vec(), exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== 31'd0) begin
      n_fail++; $display("[TB] FAIL async_reset_outputs: got %h expected 0", dut_vec());
    end
    model_reset();
    while (ph % 16 != 14) tick();
    #2 rst = 1'b0;
    repeat (50) tick();
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_lock_early: got %b expected 0", locked);
    end
    tick();
    n_checks++;
    if ({locked, fault, err_period, err_align, meas_a, meas_b, meas_c} !==
        {7'b1000000, 8'd4, 8'd8, 8'd16}) begin
      n_fail++; $display("[TB] FAIL rst_relocked: got %h expected locked with 4/8/16", dut_vec());
    end
  endtask

  // Glitch bursts alternate with clean windows long enough to lock;
  // enable drops and clears are sprinkled in at random.
  task automatic test_random();
    for (int i = 0; i < 1600; i++) begin
      glitch = ((i / 128) % 2 == 0) ? 16 : 0;
      en     = ($urandom_range(199) != 0);
      clr    = ($urandom_range(89) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    glitch = 0;
    en     = 1'b1;
    clr    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ideal_lock();
    test_b_stretch();
    test_clr_relock();
    test_c_shift();
    test_stuck_a();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/clk_edge_align_monitor.md
Name: clk_edge_align_monitor

Overview:
- Synthesizable checker that sits directly downstream of the team's aligned-clock generator.
- Samples three generated clock waveforms (fast A, mid B, slow C; nominal period ratio 1:2:4) on a faster sampling clock.
- Measures each channel's rising-edge period and checks that every B and C rising edge coincides with an A rising edge.
- Reports lock/fault status to the bench or on-chip debug logic.

Parameters:
- CNT_W, 8, width of the period counters and measured-period outputs.
- EXP_A, 4, expected rising-edge period of sig_a in clk cycles.
- EXP_B, 8, expected rising-edge period of sig_b in clk cycles.
- EXP_C, 16, expected rising-edge period of sig_c in clk cycles.
- LOCK_N, 3, consecutive error-free sig_c periods required to declare lock.

Ports:
- clk  in  1  sampling clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  monitor enable; 0 holds the FSM in IDLE and clears the arm flags.
- clr  in  1  synchronous clear of sticky error flags and fault; returns the FSM to ARMING.
- sig_a  in  1  monitored fast clock, already synchronous to clk.
- sig_b  in  1  monitored mid clock.
- sig_c  in  1  monitored slow clock.
- locked  out  1  high while the FSM is in LOCKED.
- fault  out  1  high while the FSM is in FAULT.
- err_period  out  3  sticky; bit0/1/2 = period mismatch on A/B/C.
- err_align  out  2  sticky; bit0 = B rise without A rise, bit1 = C rise without both A and B rise.
- meas_a, meas_b, meas_c  out  CNT_W each  last measured period of each channel.

Behaviour:
- Reset: all outputs 0, all counters 0, previous-sample registers 0, FSM in IDLE, arm flags cleared.
- Edge detect: each sig_x is registered into x_d. rise_x = sig_x & ~x_d, evaluated combinationally in the same cycle. No extra synchronizer.
- Period counter per channel:
  - Increments every cycle while en=1 and saturates at 2^CNT_W-1.
  - On rise_x: meas_x <= cnt_x + 1 and cnt_x <= 0.
  - The first rise after enable, reset or clr only arms the channel: meas_x updates, no compare is made.
  - Each later rise compares cnt_x+1 with EXP_x; a mismatch sets err_period[x].
  - A saturated count always mismatches.
- Alignment checks:
  - rise_b with rise_a=0 in the same cycle sets err_align[0].
  - rise_c without both rise_a and rise_b in the same cycle sets err_align[1].
  - Both checks are active only after the respective channels are armed.
- Error flags are sticky and update one cycle after the offending rise. A new error and clr in the same cycle: clr wins and the error is lost.
- FSM:
  - IDLE: en=1 -> ARMING.
  - ARMING: all three channels armed -> CHECK, good_cnt=0.
  - CHECK: each error-free rise_c increments good_cnt. When good_cnt reaches LOCK_N -> LOCKED.
  - Any new error from ARMING, CHECK or LOCKED -> FAULT.
  - FAULT: held until clr, then -> ARMING.
  - en=0 in any state -> IDLE. Sticky flags are held, counters reset, arm flags cleared.
- locked/fault are registered decodes of state and assert in the same cycle the state is entered.
- Asynchronous reset mid-operation returns everything to the reset values immediately. No partial measurement survives.
- A stuck-low or stuck-high input produces no rise, so its counter saturates. The next rise then flags a period error. A stuck channel never reaches lock.

Test Plan:
- Ideal 1:2:4 waveforms (A toggles every 2 clk, B every 4, C every 8, all rising together), en=1 -> meas_a/b/c = 4/8/16, no errors, locked=1 after the arming C rise plus 3 further C periods.
- B half-period stretched to 5 cycles once after lock -> err_period[1]=1, err_align[0]=1, fault=1, locked=0 one cycle after the bad B rise.
- C shifted one clk late while A and B are ideal -> err_align[1]=1, fault=1, err_period stays 0 after the first shifted edge.
- sig_a held low for 300 cycles, then resumed -> cnt_a saturates at 255, meas_a=255 and err_period[0]=1 on the resumed rise.
- Fault present, pulse clr with ideal waveforms -> flags clear, FSM goes to ARMING, re-locks after the arming C rise plus 3 good C periods.
- Assert rst asynchronously mid-CHECK (between clk edges) -> all outputs 0 immediately. After release, monitoring restarts from IDLE and re-locks.
